// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-detect inputs and pipeline-control outputs of the stall/flush controller.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
   logic [4:0]       id_rs1_i;
   logic [4:0]       id_rs2_i;
   logic             id_rs1_used_i;
   logic             id_rs2_used_i;
   logic [4:0]       ex_rd_i;
   logic             ex_is_load_i;
   logic             ex_redirect_i;
   logic             mem_req_i;
   logic             mem_ack_i;
   logic             pc_en_o;
   logic             if_id_en_o;
   logic             if_id_flush_o;
   logic             id_ex_en_o;
   logic             id_ex_flush_o;
   logic             ex_mem_en_o;
   logic             mem_wb_en_o;
   logic             err_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;
   modport master (
      output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
             ex_is_load_i, ex_redirect_i, mem_req_i, mem_ack_i,
      input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
             ex_mem_en_o, mem_wb_en_o, err_o, stall_cnt_o, flush_cnt_o
   );
   modport slave (
      input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
             ex_is_load_i, ex_redirect_i, mem_req_i, mem_ack_i,
      output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
             ex_mem_en_o, mem_wb_en_o, err_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for a 5-stage pipeline with memory-wait timeout and debug counters.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input logic               i_clk,
   input logic               rst_i,
   pipe_hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;
   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
   state_t           state_q, state_d;
   logic [WC_W-1:0]  wcnt_q, wcnt_d;
   logic [CNT_W-1:0] stall_q, flush_q;
   logic             freeze, load_use, go, pc_en, if_id_flush;
   assign freeze   = bus.mem_req_i & ~bus.mem_ack_i;
   assign load_use = bus.ex_is_load_i & (bus.ex_rd_i != 5'd0) &
                     ((bus.id_rs1_used_i & (bus.id_rs1_i == bus.ex_rd_i)) |
                      (bus.id_rs2_used_i & (bus.id_rs2_i == bus.ex_rd_i)));
   always_ff @(posedge i_clk or posedge rst_i)
      if (rst_i) begin
         state_q <= RUN;
         wcnt_q  <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         stall_q <= (!pc_en && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
         flush_q <= (if_id_flush && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
      end
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         RUN:
            if (freeze) begin
               state_d = (MEM_TIMEOUT <= 1) ? ERR : WAIT;
               wcnt_d  = WC_W'(1);
            end
         WAIT:
            if (!freeze) begin
               state_d = RUN;
               wcnt_d  = '0;
            end else begin
               wcnt_d  = wcnt_q + WC_W'(1);
               state_d = (wcnt_d >= WC_W'(MEM_TIMEOUT)) ? ERR : WAIT;
            end
         default: state_d = ERR;
      endcase
   end
   // go gates everything: reset, the error trap and a frozen memory stage all stop the pipe
   always_comb begin
      go          = !rst_i && state_q != ERR && !freeze;
      pc_en       = go && (bus.ex_redirect_i || !load_use);
      if_id_flush = go && bus.ex_redirect_i;
   end
   assign bus.pc_en_o       = pc_en;
   assign bus.if_id_en_o    = pc_en;
   assign bus.if_id_flush_o = if_id_flush;
   assign bus.id_ex_en_o    = go;
   assign bus.id_ex_flush_o = go && (bus.ex_redirect_i || load_use);
   assign bus.ex_mem_en_o   = go;
   assign bus.mem_wb_en_o   = go;
   assign bus.err_o         = state_q == ERR;
   assign bus.stall_cnt_o   = stall_q;
   assign bus.flush_cnt_o   = flush_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RISC-V pipeline. Drives the enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, control redirects from EX and data-memory wait states. A small FSM tracks memory waits with a timeout, and saturating counters record stall and flush activity for debug.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles allowed on one data-memory access before fatal error
CNT_W, 16, width of the stall and flush performance counters

Ports:
i_clk  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
id_rs1_i  input  5  rs1 index of instruction in ID
id_rs2_i  input  5  rs2 index of instruction in ID
id_rs1_used_i  input  1  ID instruction reads rs1
id_rs2_used_i  input  1  ID instruction reads rs2
ex_rd_i  input  5  destination register of instruction in EX
ex_is_load_i  input  1  EX instruction is a load
ex_redirect_i  input  1  EX resolved a taken branch/jump or a mispredict
mem_req_i  input  1  MEM stage holds an active load/store
mem_ack_i  input  1  data memory completes the access this cycle
pc_en_o  output  1  PC update enable
if_id_en_o  output  1  IF/ID load enable
if_id_flush_o  output  1  IF/ID loads NOP
id_ex_en_o  output  1  ID/EX load enable
id_ex_flush_o  output  1  ID/EX loads NOP
ex_mem_en_o  output  1  EX/MEM load enable
mem_wb_en_o  output  1  MEM/WB load enable
err_o  output  1  sticky memory-timeout error
stall_cnt_o  output  CNT_W  saturating count of cycles with pc_en_o=0
flush_cnt_o  output  CNT_W  saturating count of redirect flush events

Behaviour:
- Single clock domain (i_clk). rst_i is asynchronous and active-high. Reset sets state=RUN, wait counter=0, err_o=0, and both performance counters=0.
- While rst_i=1: all enables=0 and all flushes=0.
- The control outputs are combinational from the current state and inputs. They act in the same cycle and add zero latency.
- Definitions:
  - freeze = mem_req_i & ~mem_ack_i
  - load_use = ex_is_load_i & (ex_rd_i!=0) & ((id_rs1_used_i & id_rs1_i==ex_rd_i) | (id_rs2_used_i & id_rs2_i==ex_rd_i))
- Priority, evaluated in RUN and WAIT:
  1. freeze: all five enables=0, no flushes. A pending redirect or load-use is ignored this cycle and re-evaluated once freeze clears.
  2. ex_redirect_i: all enables=1, if_id_flush_o=1, id_ex_flush_o=1. This overrides load_use, because the ID instruction is squashed anyway.
  3. load_use: pc_en_o=0, if_id_en_o=0, id_ex_en_o=1 with id_ex_flush_o=1 (bubble inserted), ex_mem_en_o=1, mem_wb_en_o=1. The stall lasts exactly one cycle, since the load moves to MEM.
  4. Otherwise: all enables=1, no flushes.
- Flush takes effect only together with its enable. A flush output is never asserted while its enable is 0.
- FSM states:
  - RUN: on freeze go to WAIT with wait counter=1. Otherwise stay in RUN.
  - WAIT: on mem_ack_i, or when mem_req_i drops, return to RUN and clear the counter. That cycle is unfrozen and follows priority 2-4.
  - WAIT: otherwise increment the counter. If the counter reaches MEM_TIMEOUT while freeze is still true, go to ERR.
  - ERR: err_o=1, all enables=0, all flushes=0. Held until reset, with no exit other than rst_i.
- Zero-wait access: mem_req_i and mem_ack_i high in the same cycle means no freeze and no state change.
- Counters:
  - stall_cnt_o increments on every post-reset cycle with pc_en_o=0, including ERR.
  - flush_cnt_o increments on every cycle where if_id_flush_o=1.
  - Both saturate at all-ones and never wrap.

Test Plan:
- Load-use: EX lw with ex_rd_i=5, ID add with id_rs1_i=5 and id_rs1_used_i=1 -> one cycle with pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1. Next cycle, with EX now non-load, all enables=1. stall_cnt_o=1.
- No false hazard: ex_rd_i=0 with a matching rs1=0, or a match with id_rs2_used_i=0 -> no stall.
- Redirect with simultaneous load_use -> if_id_flush_o=1, id_ex_flush_o=1, pc_en_o=1. flush_cnt_o=1, stall_cnt_o unchanged.
- Memory wait: mem_req_i=1 with mem_ack_i held low 3 cycles, then high -> enables=0 for 3 cycles, ack cycle fully enabled, state back to RUN. stall_cnt_o=3. A redirect asserted during the wait is honoured only on the ack cycle.
- Timeout with MEM_TIMEOUT=4: mem_req_i=1, mem_ack_i=0 forever -> err_o=1 after 4 frozen cycles and stays 1. A later mem_ack_i=1 leaves all enables at 0.
- Asynchronous reset asserted mid-WAIT, between clock edges -> err_o and counters are 0 immediately and enables=0. After release, the FSM is in RUN and a zero-wait access causes no stall.
